in_injector: RTL

IN_INJECTOR -- requirements
Module: in_injector

---
 rtl/in_injector.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/in_injector.sv
// Feeds queued host bytes to the Gigatron input port, one byte per HOLD_FRAMES
// vsync periods, separated by GAP_FRAMES periods of IDLE_VALUE.
module in_injector #(
    parameter int         DEPTH       = 8,
    parameter int         HOLD_FRAMES = 2,
    parameter int         GAP_FRAMES  = 2,
    parameter logic [7:0] IDLE_VALUE  = 8'hFF
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [7:0]               i_out,
    input  logic                     i_wr_valid,
    input  logic [7:0]               i_wr_data,
    output logic                     o_wr_ready,
    output logic [7:0]               o_in,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      count_q, count_d;
    logic [7:0]      in_q, in_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [AW:0]     level_q, level_d;
    logic            prevVs_q;
    logic [7:0]      mem [DEPTH];

    logic            wrReady;
    logic            push;
    logic            pop;
    logic            vsEdge;
    logic            unusedOutBits;

    assign unusedOutBits = ^i_out[6:0];
    assign vsEdge        = prevVs_q & ~i_out[7];
    assign wrReady       = (level_q < FULL_LEVEL);
    assign push          = i_wr_valid & wrReady;

    // Pops decide on the registered level, so a byte arriving on the same
    // edge into an empty FIFO waits for the next vsync. The end of a gap
    // chains straight into the next byte to keep the gap exactly GAP_FRAMES.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        in_d    = in_q;
        pop     = 1'b0;
        if (vsEdge) begin
            case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = HOLD;
                        count_d = 8'(HOLD_FRAMES);
                        in_d    = mem[rdPtr_q];
                    end
                end
                HOLD: begin
                    if (count_q == 8'd1) begin
                        state_d = GAP;
                        count_d = 8'(GAP_FRAMES);
                        in_d    = IDLE_VALUE;
                    end else begin
                        count_d = count_q - 8'd1;
                    end
                end
                GAP: begin
                    if (count_q == 8'd1) begin
                        if (level_q != '0) begin
                            pop     = 1'b1;
                            state_d = HOLD;
                            count_d = 8'(HOLD_FRAMES);
                            in_d    = mem[rdPtr_q];
                        end else begin
                            state_d = IDLE;
                            count_d = 8'd0;
                            in_d    = IDLE_VALUE;
                        end
                    end else begin
                        count_d = count_q - 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = 8'd0;
                    in_d    = IDLE_VALUE;
                end
            endcase
        end
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + PTR_ONE : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + PTR_ONE : rdPtr_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            count_q  <= 8'd0;
            in_q     <= IDLE_VALUE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            level_q  <= '0;
            prevVs_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            in_q     <= in_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            level_q  <= level_d;
            prevVs_q <= i_out[7];
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wrPtr_q] <= i_wr_data;
        end
    end

    assign o_wr_ready = wrReady;
    assign o_in       = in_q;
    assign o_level    = level_q;
    assign o_busy     = (state_q != IDLE) || (level_q != '0);

endmodule
